// File: rtl/nibble_regfile_pkg.sv
// Shared constants and next-value helper for the nibble register file.
// Mode encoding, next-value/carry struct and the write-mode function.
package nibble_regfile_pkg;

  localparam logic [1:0] MODE_LOAD   = 2'd0;
  localparam logic [1:0] MODE_IMM_LO = 2'd1;
  localparam logic [1:0] MODE_IMM_HI = 2'd2;
  localparam logic [1:0] MODE_INC    = 2'd3;

  // Widest register the helper supports.
  localparam int unsigned MAX_W = 64;

  typedef struct packed {
    logic             carry;
    logic [MAX_W-1:0] val;
  } nr_next_t;

  // Next value of an n-bit register for the given mode.
  // The increment carries out of bit n-1 into carry.
  function automatic nr_next_t nr_next(
    input logic [MAX_W-1:0] cur,
    input logic [MAX_W-1:0] din,
    input logic [1:0]       mode,
    input int unsigned      n
  );
    nr_next_t         r;
    logic [MAX_W:0]   sum;
    logic [MAX_W:0]   sh;
    logic [MAX_W-1:0] full_m;
    logic [MAX_W-1:0] lo_m;
    full_m = {MAX_W{1'b1}} >> (MAX_W - n);
    lo_m   = full_m >> (n / 2);
    sum    = {1'b0, cur & full_m} + (MAX_W+1)'(1);
    sh     = sum >> n;
    r.val   = cur & full_m;
    r.carry = 1'b0;
    unique case (1'b1)
      mode == MODE_LOAD:
        r.val = din & full_m;
      mode == MODE_IMM_LO:
        r.val = din & lo_m;
      mode == MODE_IMM_HI:
        r.val = ((din & lo_m) << (n / 2))
              | (cur & lo_m);
      default: begin
        r.val   = sum[MAX_W-1:0] & full_m;
        r.carry = sh[0];
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/split_nibble_register.sv
// One N-bit register with independent upper/lower half write enables.
// Ports: clk, rst_n, hi_en, lo_en, hi_clr (sync upper clear), d, q.
module split_nibble_register
  import nibble_regfile_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hi_en,
  input  logic         lo_en,
  input  logic         hi_clr,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  localparam int H = N / 2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      if (hi_en)
        q[N-1:H] <= hi_clr ? '0 : d[N-1:H];
      if (lo_en)
        q[H-1:0] <= d[H-1:0];
    end
  end

endmodule

// File: rtl/nibble_register_file.sv
// Bank of split-nibble registers: one 4-mode write port, two async reads.
// Ports: clk, rst_n, wr_en/addr/mode, data_in, rd_addr_a/b, rd_data_a/b,
// wrap. Define NIBBLE_REGFILE_BYPASS_EN for write-to-read forwarding.
module nibble_register_file
  import nibble_regfile_pkg::*;
#(
  parameter  int N        = 8,
  parameter  int NUM_REGS = 4,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [1:0]    wr_mode,
  input  logic [N-1:0]  data_in,
  input  logic [AW-1:0] rd_addr_a,
  output logic [N-1:0]  rd_data_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [N-1:0]  rd_data_b,
  output logic          wrap
);

  logic [N-1:0]        q [NUM_REGS];
  logic [N-1:0]        cur;
  logic [N-1:0]        nxt_val;
  logic                nxt_carry;
  nr_next_t            nxt;
  logic                unused_bits;
  logic [NUM_REGS-1:0] sel;
  logic                hi_en;
  logic                lo_en;
  logic                hi_clr;

  assign cur = q[wr_addr];

  assign nxt = nr_next(MAX_W'(cur),
                       MAX_W'(data_in),
                       wr_mode, N);

  assign nxt_val     = nxt.val[N-1:0];
  assign nxt_carry   = nxt.carry;
  assign unused_bits = ^nxt.val;

  assign sel    = NUM_REGS'(1) << wr_addr;
  assign hi_en  = wr_en;
  assign lo_en  = wr_en & (wr_mode != MODE_IMM_HI);
  assign hi_clr = (wr_mode == MODE_IMM_LO);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    split_nibble_register #(
      .N(N)
    ) u_reg (
      .clk    (clk),
      .rst_n  (rst_n),
      .hi_en  (hi_en & sel[i]),
      .lo_en  (lo_en & sel[i]),
      .hi_clr (hi_clr),
      .d      (nxt_val),
      .q      (q[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wrap <= 1'b0;
    else
      wrap <= wr_en
            & (wr_mode == MODE_INC)
            & nxt_carry;
  end

`ifdef NIBBLE_REGFILE_BYPASS_EN
  // Forwarding is masked in reset so reads stay 0 there.
  logic fwd_a;
  logic fwd_b;
  assign fwd_a = wr_en & rst_n
               & (rd_addr_a == wr_addr);
  assign fwd_b = wr_en & rst_n
               & (rd_addr_b == wr_addr);
  assign rd_data_a = fwd_a ? nxt_val
                           : q[rd_addr_a];
  assign rd_data_b = fwd_b ? nxt_val
                           : q[rd_addr_b];
`else
  assign rd_data_a = q[rd_addr_a];
  assign rd_data_b = q[rd_addr_b];
`endif

endmodule
